// File: rtl/byte_mult_sequencer_if.sv
// Operand handshake and accumulator-facing bus of byte_mult_sequencer.
// slave = the sequencer itself; master = the operand source / observer side.
interface byte_mult_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        start;
   logic [15:0] mult_out;
   logic [3:0]  pp_idx;
   logic        busy;
   logic        product_valid;

   modport slave (
      input  in_valid, op_a, op_b,
      output in_ready, start, mult_out, pp_idx, busy, product_valid
   );

   modport master (
      output in_valid, op_a, op_b,
      input  in_ready, start, mult_out, pp_idx, busy, product_valid
   );
endinterface

// File: rtl/byte_mult_sequencer.sv
// Feeds a 16-pass byte-serial 32x32 accumulator: latches operands, drives start, issues A[i]*B[j].
// Optional REGISTERED_MULT_EN registers the 8x8 product; external timing is identical either way.
module byte_mult_sequencer (
   input  logic                  clk,
   input  logic                  reset,
   byte_mult_sequencer_if.slave  bus
);
   localparam int PP_COUNT = 16;

   typedef enum logic [2:0] {IDLE, START, RUN, DONE, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_q, b_q;
   logic [3:0]  idx_q, idx_nxt;
   logic        start_q, start_nxt;
   logic        busy_q, busy_nxt;
   logic        rdy_q, rdy_nxt;
   logic        pv_q, pv_nxt;
   logic [15:0] mult;
   logic        take;

   // pp index k: A byte = k[1:0], B byte = k[3:2]
   function automatic logic [15:0] byte_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] k);
      logic [7:0] ab, bb;
      ab = a[{k[1:0], 3'b000} +: 8];
      bb = b[{k[3:2], 3'b000} +: 8];
      return {8'h00, ab} * {8'h00, bb};
   endfunction

   assign take = bus.in_valid & rdy_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = START;
         START:   state_nxt = RUN;
         RUN:     if (idx_q == 4'(PP_COUNT - 1)) state_nxt = DONE;
         DONE:    state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs are computed from the next state and registered, so start is glitch-free.
   always_comb begin
      start_nxt = (state_nxt == START) || (state_nxt == RUN) || (state_nxt == DONE);
      busy_nxt  = (state_nxt != IDLE);
      rdy_nxt   = (state_nxt == IDLE);
      pv_nxt    = (state_nxt == DONE);
      idx_nxt   = 4'd0;
      if (state_nxt == RUN && state == RUN) idx_nxt = idx_q + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
         pv_q    <= 1'b0;
         idx_q   <= 4'd0;
      end else begin
         start_q <= start_nxt;
         busy_q  <= busy_nxt;
         rdy_q   <= rdy_nxt;
         pv_q    <= pv_nxt;
         idx_q   <= idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= 32'd0;
         b_q <= 32'd0;
      end else if (take) begin
         a_q <= bus.op_a;
         b_q <= bus.op_b;
      end
   end

`ifdef REGISTERED_MULT_EN
   // Issue index leads pp_idx by one: pair 0 is selected in START, pair k+1 while pp_idx=k.
   logic [3:0]  iss;
   logic [15:0] mult_q;

   assign iss = (state == RUN) ? idx_q + 4'd1 : 4'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                mult_q <= 16'd0;
      else if (state_nxt == RUN) mult_q <= byte_prod(a_q, b_q, iss);
      else                       mult_q <= 16'd0;
   end

   assign mult = mult_q;
`else
   assign mult = (state == RUN) ? byte_prod(a_q, b_q, idx_q) : 16'd0;
`endif

   assign bus.in_ready      = rdy_q;
   assign bus.start         = start_q;
   assign bus.busy          = busy_q;
   assign bus.product_valid = pv_q;
   assign bus.pp_idx        = idx_q;
   assign bus.mult_out      = mult;
endmodule

// File: tb/tb_byte_mult_sequencer.sv
// Randomized bench: cycle-table model of the sequencer plus a downstream accumulator
// that rebuilds the 64-bit product from mult_out and compares it with A*B.
module tb_byte_mult_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   byte_mult_sequencer_if bus();

   byte_mult_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected byte product for index k from plain arithmetic on the operands.
   function automatic longint unsigned exp_pp(input longint unsigned a, input longint unsigned b,
                                              input int k);
      return ((a >> (8 * (k % 4))) & 64'hFF) * ((b >> (8 * (k / 4))) & 64'hFF);
   endfunction

   task automatic chk_idle_outs(input string tag);
      chk({tag, " start"}, 64'(bus.start), 64'd0);
      chk({tag, " busy"},  64'(bus.busy), 64'd0);
      chk({tag, " pv"},    64'(bus.product_valid), 64'd0);
      chk({tag, " idx"},   64'(bus.pp_idx), 64'd0);
      chk({tag, " mult"},  64'(bus.mult_out), 64'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(bus.in_ready), 64'd1);
   endtask

   // Offer (a,b) at a negedge with in_ready high; cycle c counts from the accept edge.
   // hold=1 keeps in_valid high with fresh junk operands, which must be ignored.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
      longint unsigned acc = 0;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      for (int c = 1; c <= 19; c++) begin
         bit run;
         int k;
         @(negedge clk);
         if (hold) begin
            bus.op_a = $urandom;
            bus.op_b = $urandom;
         end else begin
            bus.in_valid = 1'b0;
         end
         run = (c >= 2) && (c <= 17);
         k   = run ? c - 2 : 0;
         chk($sformatf("start c%0d", c), 64'(bus.start), 64'(c <= 18));
         chk($sformatf("busy c%0d", c),  64'(bus.busy), 64'd1);
         chk($sformatf("rdy c%0d", c),   64'(bus.in_ready), 64'd0);
         chk($sformatf("pv c%0d", c),    64'(bus.product_valid), 64'(c == 18));
         chk($sformatf("idx c%0d", c),   64'(bus.pp_idx), 64'(k));
         chk($sformatf("mult c%0d", c),  64'(bus.mult_out), run ? exp_pp(64'(a), 64'(b), k) : 64'd0);
         if (run) acc += 64'(bus.mult_out) << (8 * ((k % 4) + (k / 4)));
         if (c == 18) chk("product", acc, 64'(a) * 64'(b));
      end
      @(negedge clk);
      chk("c20 rdy", 64'(bus.in_ready), 64'd1);
      chk("c20 start", 64'(bus.start), 64'd0);
      chk("c20 busy", 64'(bus.busy), 64'd0);
   endtask

   // Reset lands at pp_idx=7 (cycle 9); everything must clear at once and nothing may complete.
   task automatic abort_op(input logic [31:0] a, input logic [31:0] b);
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      chk("abort idx7", 64'(bus.pp_idx), 64'd7);
      chk("abort start_hi", 64'(bus.start), 64'd1);
      reset = 1'b0;
      #1;
      chk_idle_outs("abort");
      chk("abort rdy", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort no_pv", 64'(bus.product_valid), 64'd0);
         chk("abort no_start", 64'(bus.start), 64'd0);
         if (i == 2) reset = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      repeat (3) @(negedge clk);
      chk_idle_outs("in_reset");
      chk("in_reset rdy", 64'(bus.in_ready), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outs("post_reset");
      chk("post_reset rdy", 64'(bus.in_ready), 64'd1);

      run_op(32'h0000_0001, 32'h0000_0001, 1'b0);
      run_op(32'h0403_0201, 32'h0807_0605, 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      // back-to-back with in_valid held: accepts only at cycles 0 and 20
      run_op($urandom, $urandom, 1'b1);
      run_op($urandom, $urandom, 1'b1);
      bus.in_valid = 1'b0;

      abort_op($urandom, $urandom);
      run_op(32'h0000_0003, 32'h0000_0005, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
